// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int INSTR_BYTES     = 4;
  localparam int FETCH_BUF_DEPTH = 2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One buffered fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetch entries between the PC stage and decode.
// Entry 0 is always the head, so the head outputs come straight from a register.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  logic [1:0]   count_q;
  fetch_entry_t entry0_q;
  fetch_entry_t entry1_q;
  logic         popOk;
  logic         pushOk;

  // Qualify the requests so a stray pop on empty or push on full cannot corrupt the FIFO.
  always_comb begin
    popOk  = pop_i && (count_q != 2'd0);
    pushOk = push_i && ((count_q < 2'(FETCH_BUF_DEPTH)) || popOk);
  end

  // Head-anchored FIFO update; flush wins over push and pop, and an empty buffer keeps its last head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      entry0_q <= '0;
      entry1_q <= '0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else begin
      case ({pushOk, popOk})
        2'b10: begin
          if (count_q == 2'd0) begin
            entry0_q <= push_entry_i;
          end else begin
            entry1_q <= push_entry_i;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            entry0_q <= entry1_q;
          end
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            entry0_q <= entry1_q;
            entry1_q <= push_entry_i;
          end else begin
            entry0_q <= push_entry_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = entry0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, addresses instr_mem and feeds decode
// through a two-entry buffer. The buffer entry format is fixed at 32-bit fields by fetch_pkg.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0]    instr,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [ADDRESS_WIDTH-1:0] out_pc_plus4
);

  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] pc_d;
  logic                     pop;
  logic                     push;
  logic [1:0]               count;
  fetch_entry_t             newEntry;
  fetch_entry_t             head;

  // Handshake and next-PC selection; a redirect suppresses the fetch and realigns the target.
  always_comb begin
    pop  = out_valid && out_ready;
    push = fetch_en && !redirect_valid && ((count < 2'(FETCH_BUF_DEPTH)) || pop);
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
    end
    newEntry.instr = instr;
    newEntry.pc    = pc_q;
  end

  // PC register, driven straight onto the instruction memory address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_entry_i (newEntry),
    .pop_i        (pop),
    .count_o      (count),
    .head_o       (head)
  );

  assign instr_addr   = pc_q;
  assign out_valid    = (count != 2'd0);
  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign out_pc_plus4 = head.pc + ADDRESS_WIDTH'(INSTR_BYTES);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a queue-based model of the fetch stage.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int compared;
  int mismatched;

  fetch_entry_t modelQ[$];
  logic [31:0]  modelPc;
  logic [31:0]  heldAddr;

  fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_addr     (instr_addr),
    .instr          (instr),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory responds combinationally with an address-derived word.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign instr = memWord(instr_addr);

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every visible output with the reference model.
  task automatic checkModel();
    checkOutput("instr_addr", instr_addr, modelPc);
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, (modelQ.size() > 0)});
    if (modelQ.size() > 0) begin
      checkOutput("out_pc", out_pc, modelQ[0].pc);
      checkOutput("out_instr", out_instr, modelQ[0].instr);
      checkOutput("out_pc_plus4", out_pc_plus4, modelQ[0].pc + 32'd4);
    end
  endtask

  // Drive one cycle of inputs, advance the model by that cycle, then check after the edge.
  task automatic applyStimulus(input logic rstN, input logic ready, input logic fen,
                               input logic redir, input logic [31:0] rpc);
    logic         doPop;
    logic         doPush;
    fetch_entry_t e;
    rst_n          = rstN;
    out_ready      = ready;
    fetch_en       = fen;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (!rstN) begin
      modelQ.delete();
      modelPc = 32'h0;
    end else begin
      doPop  = (modelQ.size() > 0) && ready;
      doPush = fen && !redir && ((modelQ.size() < 2) || doPop);
      if (redir) begin
        modelQ.delete();
        modelPc = rpc & 32'hFFFF_FFFC;
      end else begin
        if (doPop) void'(modelQ.pop_front());
        if (doPush) begin
          e.instr = memWord(modelPc);
          e.pc    = modelPc;
          modelQ.push_back(e);
          modelPc = modelPc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    checkModel();
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    modelPc        = 32'h0;
    #2;

    // Reset, then sequential fetch at full throughput.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rst_out_instr", out_instr, 32'h0);
    checkOutput("rst_out_pc", out_pc, 32'h0);
    checkOutput("rst_out_pc_plus4", out_pc_plus4, 32'h4);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("seq_out_pc", out_pc, 32'(4 * k));
      checkOutput("seq_out_valid", {31'b0, out_valid}, 32'h1);
    end

    // Drain, then stall decode for five cycles from empty: buffer fills, PC stalls at base+8.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    heldAddr = modelPc;
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("stall_addr", instr_addr, heldAddr + 32'd8);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect while full with decode ready: flush, aligned target, old entries gone.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0102);
    checkOutput("redir_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("redir_addr", instr_addr, 32'h0000_0100);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir_head_pc", out_pc, 32'h0000_0100);

    // Address wrap at the top of memory.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    checkOutput("wrap_addr", instr_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_pc", out_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4", out_pc_plus4, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_next_pc", out_pc, 32'h0);

    // fetch_en low with two buffered: both drain, address holds, then resume.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    heldAddr = modelPc;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("drain_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("drain_addr", instr_addr, heldAddr);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("resume_pc", out_pc, heldAddr);

    // Reset together with a redirect: reset wins.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0400);
    checkOutput("rst2_addr", instr_addr, 32'h0);
    checkOutput("rst2_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst2_out_instr", out_instr, 32'h0);
    checkOutput("rst2_out_pc", out_pc, 32'h0);
    checkOutput("rst2_out_pc_plus4", out_pc_plus4, 32'h4);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic        rReady;
      logic        rFen;
      logic        rRedir;
      logic [31:0] rTarget;
      rReady  = ($urandom_range(0, 9) < 7);
      rFen    = ($urandom_range(0, 9) < 8);
      rRedir  = ($urandom_range(0, 19) == 0);
      rTarget = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      applyStimulus(($urandom_range(0, 99) != 0), rReady, rFen, rRedir, rTarget);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage front end: owns the program counter, drives the address side of `instr_mem`, and captures the returned instruction into a 2-entry fetch buffer presented to decode with a valid/ready handshake. It sits between `instr_mem` (combinational responder) and the IF/ID boundary, and accepts control-flow redirects from execute.

## Interface

- `ADDRESS_WIDTH`, 32, PC / instruction address width
- `DATA_WIDTH`, 32, instruction width
- `RESET_PC`, 0, PC value loaded on reset; bits [1:0] must be 0
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `instr_addr`  out  ADDRESS_WIDTH  address to `instr_mem`, equals PC register
- `instr`  in  DATA_WIDTH  instruction from `instr_mem`, valid same cycle as `instr_addr`
- `fetch_en`  in  1  permits fetching; low holds PC, no push
- `redirect_valid`  in  1  flush and load new PC
- `redirect_pc`  in  ADDRESS_WIDTH  redirect target; bits [1:0] ignored (treated as 0)
- `out_valid`  out  1  buffer head holds a valid instruction
- `out_ready`  in  1  decode accepts head this cycle
- `out_instr`  out  DATA_WIDTH  head instruction
- `out_pc`  out  ADDRESS_WIDTH  PC of head instruction
- `out_pc_plus4`  out  ADDRESS_WIDTH  `out_pc + 4`, modulo 2^ADDRESS_WIDTH

## Operation

- Reset (`rst_n`=0 at edge): PC←RESET_PC, buffer count←0, all entries←0. Outputs after reset: `instr_addr`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_pc_plus4`=4. Reset overrides all other inputs.
- pop = `out_valid & out_ready`.
- push = `fetch_en & ~redirect_valid & (count<2 | pop)`.
- On push: entry {`instr`, PC} written at tail; PC←PC+4 (wraps 0xFFFF_FFFC→0x0000_0000).
- push & pop same cycle: count unchanged, head advances, new entry appended; full buffer with pop still fetches (full throughput, 1 instr/cycle).
- Full (count=2) & no pop: no push, PC held, `instr_addr` stable.
- Empty: `out_valid`=0; `out_*` hold last head contents, don't-care for decode.
- Redirect: PC←{redirect_pc[ADDRESS_WIDTH-1:2],2'b00}, count←0, no push that cycle. Any pop in the same cycle is discarded by the flush. Redirect takes effect regardless of `fetch_en` or buffer state.
- `fetch_en`=0: PC held, no push; pops continue draining buffer.
- Buffer is FIFO-ordered; entries never reordered or duplicated.

## Timing

- `instr_addr` is a direct register output (no combinational path from any input).
- `out_valid`/`out_*` are register outputs; no combinational path from `out_ready` or `redirect_valid` to any output.
- Fetch latency: PC presented in cycle N → `out_valid`=1 with that instruction in N+1 (buffer previously empty).
- Redirect asserted in cycle N → `out_valid`=0 in N+1, `instr_addr`=target in N+1, target instruction at head in N+2.
- Steady state with `out_ready`=1: one instruction per cycle, sequential PCs.
- `out_ready` low for k cycles from empty: buffer fills to 2 in 2 cycles, PC then stalls at base+8.

## Structure

- Shared package `fetch_pkg`: `INSTR_BYTES`=4, `FETCH_BUF_DEPTH`=2, `NOP_INSTR`=32'h0000_0013, `fetch_entry_t` struct {instr, pc}.
- Sub-module `fetch_buffer`: 2-entry FIFO of `fetch_entry_t` with push, pop, synchronous flush, count, head outputs; flush priority over push/pop. Top level holds PC register and push/pop logic.

## Test plan

- Reset release, RESET_PC=0, `fetch_en`=1, `out_ready`=1, memory returns addr-derived word → `out_pc` 0,4,8,12 on consecutive cycles starting 1 cycle after first fetch, `out_pc_plus4` = `out_pc`+4.
- `out_ready`=0 for 5 cycles from empty → count reaches 2, `instr_addr` stalls at 0x8, no instruction lost or duplicated after `out_ready`=1.
- Redirect to 0x0000_0102 while buffer full and `out_ready`=1 → next cycle `out_valid`=0, `instr_addr`=0x100; following cycle `out_pc`=0x100; old entries never appear.
- PC=0xFFFF_FFFC sequential fetch → next `out_pc`=0x0, `out_pc_plus4` for 0xFFFF_FFFC entry = 0x0.
- `fetch_en`=0 mid-stream with 2 buffered → both drain, `out_valid` drops, `instr_addr` constant; re-enable resumes at held PC.
- `rst_n`=0 asserted for one cycle concurrent with `redirect_valid`=1 → post-reset `instr_addr`=RESET_PC, `out_valid`=0, all `out_*` reset values.
